// File: rtl/ft_pkg.sv
// Shared types and helpers for the ternary flow-table lookup: entry layout,
// pipeline depth and a saturating increment used by the hit and miss counters.
package ft_pkg;

    localparam int FT_KEY_W   = 32;
    localparam int FT_ACT_W   = 4;
    localparam int FT_LATENCY = 3;

    typedef struct packed {
        logic                valid;
        logic [FT_KEY_W-1:0] key;
        logic [FT_KEY_W-1:0] mask;
        logic [FT_ACT_W-1:0] action;
    } ft_entry_t;

    // Holds at the all-ones value of a counter that is `width` bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = {64{1'b1}} >> (64 - width);
        return (value == max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/ft_match_entry.sv
// One flow-table entry: storage written by the control plane and a ternary
// compare of the S1 key against it.
module ft_match_entry
    import ft_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  ft_entry_t           wr_entry,
    input  logic [FT_KEY_W-1:0] lookup_key,
    output ft_entry_t           entry_out,
    output logic                hit
);

    ft_entry_t entry_q;
    ft_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (wr_en) begin
            entry_d = wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    // Mask bit 1 means the key bit takes part in the compare.
    assign hit       = entry_q.valid && (((lookup_key ^ entry_q.key) & entry_q.mask) == '0);
    assign entry_out = entry_q;

endmodule

// File: rtl/flow_table_lookup.sv
// Ternary flow-table lookup: 3-stage pipeline, lowest-index priority, per-entry saturating hit counters.
// Defining FT_MISS_COUNT_EN adds a saturating miss counter exported on miss_count_out.
module flow_table_lookup
    import ft_pkg::*;
#(
    parameter int                     KEY_W          = FT_KEY_W,
    parameter int                     FT_ADDR_WIDTH  = 5,
    parameter int                     FT_DEPTH       = 32,
    parameter int                     NUM_ACTIONS    = FT_ACT_W,
    parameter int                     TID_W          = 3,
    parameter int                     CNT_W          = 32,
    parameter logic [NUM_ACTIONS-1:0] DEFAULT_ACTION = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_in,
    input  logic [KEY_W-1:0]         key_in,
    input  logic [TID_W-1:0]         thread_id_in,
    input  logic                     setup_ft,
    input  logic [FT_ADDR_WIDTH-1:0] ft_addr,
    input  logic [KEY_W-1:0]         ft_key,
    input  logic [KEY_W-1:0]         ft_mask,
    input  logic [NUM_ACTIONS-1:0]   ft_action,
    input  logic                     ft_valid,
    input  logic                     read_counter,
    input  logic [FT_ADDR_WIDTH-1:0] counter_rd_addr_in,
    output logic                     acc_done,
    output logic                     match_true,
    output logic [NUM_ACTIONS-1:0]   action_out,
    output logic [FT_ADDR_WIDTH-1:0] match_addr_out,
    output logic [TID_W-1:0]         thread_id_out,
    output logic [CNT_W-1:0]         count_out,
    output logic                     count_valid
`ifdef FT_MISS_COUNT_EN
    ,
    output logic [CNT_W-1:0]         miss_count_out
`endif
);

    localparam logic [FT_ADDR_WIDTH:0] DEPTH_LIM = (FT_ADDR_WIDTH+1)'(FT_DEPTH);

    ft_entry_t                wr_entry;
    ft_entry_t                wr_old;
    ft_entry_t                entry_arr [FT_DEPTH];
    logic [FT_DEPTH-1:0]      entry_hit;
    logic [FT_DEPTH-1:0]      wr_en;
    logic                     wr_ok;

    logic [FT_LATENCY-1:0]    vld_q, vld_d;
    logic [KEY_W-1:0]         key_s1_q, key_s1_d;
    logic [TID_W-1:0]         tid_s1_q, tid_s1_d;
    logic [FT_DEPTH-1:0]      hit_s2_q, hit_s2_d;
    logic [TID_W-1:0]         tid_s2_q, tid_s2_d;

    logic                     sh1_vld_q, sh1_vld_d;
    logic [FT_ADDR_WIDTH-1:0] sh1_idx_q, sh1_idx_d;
    ft_entry_t                sh1_entry_q, sh1_entry_d;
    logic                     sh1_hit;
    logic                     sh2_vld_q, sh2_vld_d;
    logic [FT_ADDR_WIDTH-1:0] sh2_idx_q, sh2_idx_d;
    logic [NUM_ACTIONS-1:0]   sh2_act_q, sh2_act_d;

    logic                     win_hit;
    logic [FT_ADDR_WIDTH-1:0] win_idx;
    logic [NUM_ACTIONS-1:0]   win_act;

    logic                     match_q, match_d;
    logic [NUM_ACTIONS-1:0]   action_q, action_d;
    logic [FT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TID_W-1:0]         tid_q, tid_d;

    logic [CNT_W-1:0]         cnt_q [FT_DEPTH];
    logic [CNT_W-1:0]         cnt_d [FT_DEPTH];
    logic [CNT_W-1:0]         rd_val;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     count_valid_q, count_valid_d;

    assign wr_ok = setup_ft && ({1'b0, ft_addr} < DEPTH_LIM);

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = ft_valid;
        wr_entry.key    = ft_key;
        wr_entry.mask   = ft_mask;
        wr_entry.action = ft_action;
    end

    for (genvar g = 0; g < FT_DEPTH; g++) begin : g_entry
        assign wr_en[g] = wr_ok && (ft_addr == FT_ADDR_WIDTH'(g));

        ft_match_entry u_entry (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en[g]),
            .wr_entry   (wr_entry),
            .lookup_key (key_s1_q),
            .entry_out  (entry_arr[g]),
            .hit        (entry_hit[g])
        );
    end

    // Entries update at the write edge, but a lookup must see the table as it
    // stood in its start cycle. The overwritten contents are kept for two cycles
    // so S2 (compare) and S3 (action select) can substitute them.
    always_comb begin
        wr_old = '0;
        for (int i = 0; i < FT_DEPTH; i++) begin
            if (ft_addr == FT_ADDR_WIDTH'(i)) begin
                wr_old = entry_arr[i];
            end
        end
        sh1_vld_d   = wr_ok;
        sh1_idx_d   = ft_addr;
        sh1_entry_d = wr_old;
        sh2_vld_d   = sh1_vld_q;
        sh2_idx_d   = sh1_idx_q;
        sh2_act_d   = sh1_entry_q.action;
    end

    assign sh1_hit = sh1_entry_q.valid && (((key_s1_q ^ sh1_entry_q.key) & sh1_entry_q.mask) == '0);

    always_comb begin
        vld_d    = {vld_q[FT_LATENCY-2:0], start_in};
        key_s1_d = key_in;
        tid_s1_d = thread_id_in;
        tid_s2_d = tid_s1_q;
        for (int i = 0; i < FT_DEPTH; i++) begin
            hit_s2_d[i] = (sh1_vld_q && (sh1_idx_q == FT_ADDR_WIDTH'(i))) ? sh1_hit : entry_hit[i];
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = FT_DEPTH - 1; i >= 0; i--) begin
            if (hit_s2_q[i]) begin
                win_hit = 1'b1;
                win_idx = FT_ADDR_WIDTH'(i);
            end
        end
        win_act = DEFAULT_ACTION;
        for (int i = 0; i < FT_DEPTH; i++) begin
            if (win_idx == FT_ADDR_WIDTH'(i)) begin
                win_act = entry_arr[i].action;
            end
        end
        // The older overwrite takes precedence: it holds the start-cycle contents.
        if (sh1_vld_q && (sh1_idx_q == win_idx)) begin
            win_act = sh1_entry_q.action;
        end
        if (sh2_vld_q && (sh2_idx_q == win_idx)) begin
            win_act = sh2_act_q;
        end
    end

    always_comb begin
        match_d  = match_q;
        action_d = action_q;
        addr_d   = addr_q;
        tid_d    = tid_q;
        if (vld_q[1]) begin
            match_d  = win_hit;
            action_d = win_hit ? win_act : DEFAULT_ACTION;
            addr_d   = win_hit ? win_idx : '0;
            tid_d    = tid_s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            key_s1_q    <= '0;
            tid_s1_q    <= '0;
            hit_s2_q    <= '0;
            tid_s2_q    <= '0;
            sh1_vld_q   <= 1'b0;
            sh1_idx_q   <= '0;
            sh1_entry_q <= '0;
            sh2_vld_q   <= 1'b0;
            sh2_idx_q   <= '0;
            sh2_act_q   <= '0;
            match_q     <= 1'b0;
            action_q    <= DEFAULT_ACTION;
            addr_q      <= '0;
            tid_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            key_s1_q    <= key_s1_d;
            tid_s1_q    <= tid_s1_d;
            hit_s2_q    <= hit_s2_d;
            tid_s2_q    <= tid_s2_d;
            sh1_vld_q   <= sh1_vld_d;
            sh1_idx_q   <= sh1_idx_d;
            sh1_entry_q <= sh1_entry_d;
            sh2_vld_q   <= sh2_vld_d;
            sh2_idx_q   <= sh2_idx_d;
            sh2_act_q   <= sh2_act_d;
            match_q     <= match_d;
            action_q    <= action_d;
            addr_q      <= addr_d;
            tid_q       <= tid_d;
        end
    end

    // A table write clears the counter and overrides a same-cycle increment.
    always_comb begin
        for (int i = 0; i < FT_DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (vld_q[1] && win_hit && (win_idx == FT_ADDR_WIDTH'(i))) begin
                cnt_d[i] = CNT_W'(sat_inc(64'(cnt_q[i]), CNT_W));
            end
            if (wr_en[i]) begin
                cnt_d[i] = '0;
            end
        end
    end

`ifdef FT_MISS_COUNT_EN
    localparam logic [FT_ADDR_WIDTH-1:0] MISS_ADDR    = '1;
    localparam bit                       MISS_ADDR_OK = ((1 << FT_ADDR_WIDTH) - 1) >= FT_DEPTH;

    logic [CNT_W-1:0] miss_q, miss_d;
    logic             miss_rd;

    assign miss_rd = read_counter && MISS_ADDR_OK && (counter_rd_addr_in == MISS_ADDR);

    always_comb begin
        miss_d = miss_rd ? '0 : miss_q;
        if (vld_q[1] && !win_hit) begin
            miss_d = CNT_W'(sat_inc(64'(miss_d), CNT_W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_count_out = miss_q;
`endif

    // Out-of-range addresses fall through the mux and read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < FT_DEPTH; i++) begin
            if (counter_rd_addr_in == FT_ADDR_WIDTH'(i)) begin
                rd_val = cnt_q[i];
            end
        end
        count_valid_d = read_counter;
        count_d       = count_q;
        if (read_counter) begin
            count_d = rd_val;
`ifdef FT_MISS_COUNT_EN
            if (miss_rd) begin
                count_d = miss_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FT_DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            count_q       <= '0;
            count_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < FT_DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign acc_done       = vld_q[FT_LATENCY-1];
    assign match_true     = match_q;
    assign action_out     = action_q;
    assign match_addr_out = addr_q;
    assign thread_id_out  = tid_q;
    assign count_out      = count_q;
    assign count_valid    = count_valid_q;

endmodule
